// File: rtl/lifting_split.sv
// rtl/lifting_split.sv - lazy-wavelet split: serial samples to registered (even, odd) pairs
//
// Front stage of the forward DWT lifting datapath. It deinterleaves one
// serial row of signed samples into (x[2k], x[2k+1]) pairs. A row of odd
// length is closed by repeating its last sample as the odd partner
// (symmetric extension), and that pair is flagged with pair_pad.
//
// Ports:
//   clk, rst                 single rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_last serial sample stream; in_last marks the row's final sample
//   in_ready                 sample accepted this cycle when high together with in_valid
//   even_out/odd_out         registered pair (odd_out replicates even_out when padded)
//   pair_idx                 pair index k within the row, wraps modulo 2^IDX_W
//   pair_pad                 odd_out is an extension value, not a real sample
//   pair_last                final pair of the row
//   out_valid/out_ready      pair handshake towards predict/update

module lifting_split #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [DATA_W-1:0] even_out,
   output logic [DATA_W-1:0] odd_out,
   output logic [IDX_W-1:0]  pair_idx,
   output logic              pair_pad,
   output logic              pair_last,
   output logic              out_valid,
   input  logic              out_ready
);

   logic [DATA_W-1:0] hold;
   logic              hold_vld;
   logic              out_vld;
   logic [IDX_W-1:0]  idx;

   logic              in_xfer;
   logic              out_xfer;
   logic              load_pair;

   // A sample may be taken whenever the pair register is empty or is being
   // drained this cycle; even samples also stall under backpressure so the
   // row order can never run ahead of the pair register.
   assign in_ready  = !out_vld || out_ready;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_vld && out_ready;
   // A pair completes on an odd-position sample, or on a lone even sample
   // that ends the row.
   assign load_pair = in_xfer && (hold_vld || in_last);
   assign out_valid = out_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold      <= '0;
         hold_vld  <= 1'b0;
         out_vld   <= 1'b0;
         idx       <= '0;
         even_out  <= '0;
         odd_out   <= '0;
         pair_idx  <= '0;
         pair_pad  <= 1'b0;
         pair_last <= 1'b0;
      end else begin
         // A new pair overrides a drain in the same cycle, keeping full rate.
         if (load_pair) begin
            out_vld <= 1'b1;
         end else if (out_xfer) begin
            out_vld <= 1'b0;
         end

         if (in_xfer) begin
            if (hold_vld) begin
               even_out  <= hold;
               odd_out   <= in_data;
               pair_pad  <= 1'b0;
               pair_last <= in_last;
               pair_idx  <= idx;
               hold_vld  <= 1'b0;
               idx       <= in_last ? '0 : idx + 1'b1;
            end else if (in_last) begin
               // Odd-length row: mirror the final sample into the odd slot.
               even_out  <= in_data;
               odd_out   <= in_data;
               pair_pad  <= 1'b1;
               pair_last <= 1'b1;
               pair_idx  <= idx;
               idx       <= '0;
            end else begin
               hold     <= in_data;
               hold_vld <= 1'b1;
            end
         end
      end
   end

endmodule
